present_enc: RTL and testbench

Iterative PRESENT-80 encryption core, one round per clock. It is the round datapath that drives the team's 4-bit PRESENT `sbox` cell: addRoundKey, then an S-box layer of 16 `sbox` instances, then pLayer, with a key schedule that uses one more `sbox` instance. It accepts a 64-bit plaintext and an 80-bit key through a start/done handshake and returns the 64-bit ciphertext.

---
 rtl/present_pkg.sv | 27 ++
 rtl/present_key_schedule.sv | 22 ++
 rtl/sbox.sv | 30 +++
 rtl/present_enc.sv | 87 ++++++++
 tb/tb_present_enc.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/present_pkg.sv
// Shared widths, FSM encoding, pLayer wiring and the PRESENT S-box table.
// The table is a reference copy; the hardware uses the sbox cell.
package present_pkg;

  localparam int STATE_W = 64;
  localparam int KEY_W   = 80;
  localparam int RC_W    = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Nibble x of S_TABLE holds S(x).
  localparam logic [63:0] S_TABLE = 64'h2174_8FE3_DA09_B65C;

  // Bit i moves to (16*i) mod 63; bit 63 is fixed.
  function automatic logic [STATE_W-1:0] player(input logic [STATE_W-1:0] d);
    logic [STATE_W-1:0] p;
    p = '0;
    for (int i = 0; i < STATE_W - 1; i++) begin
      p[(16 * i) % 63] = d[i];
    end
    p[STATE_W-1] = d[STATE_W-1];
    return p;
  endfunction

endpackage

// File: rtl/present_key_schedule.sv
// Combinational PRESENT-80 key update: rotate, S-box the top nibble, mix in the round counter.
module present_key_schedule
  import present_pkg::*;
(
  input  logic [KEY_W-1:0] k,
  input  logic [RC_W-1:0]  rc,
  output logic [KEY_W-1:0] k_next
);

  logic [KEY_W-1:0] rot;
  logic [3:0]       top_sub;

  assign rot = {k[18:0], k[79:19]};

  sbox u_sbox (
    .nibble (rot[79:76]),
    .subst  (top_sub)
  );

  assign k_next = {top_sub, rot[75:20], rot[19:15] ^ rc, rot[14:0]};

endmodule

// File: rtl/sbox.sv
// 4-bit PRESENT S-box cell.
module sbox (
  input  logic [3:0] nibble,
  output logic [3:0] subst
);

  always_comb begin
    subst = 4'h0;
    case (nibble)
      4'h0: subst = 4'hC;
      4'h1: subst = 4'h5;
      4'h2: subst = 4'h6;
      4'h3: subst = 4'hB;
      4'h4: subst = 4'h9;
      4'h5: subst = 4'h0;
      4'h6: subst = 4'hA;
      4'h7: subst = 4'hD;
      4'h8: subst = 4'h3;
      4'h9: subst = 4'hE;
      4'hA: subst = 4'hF;
      4'hB: subst = 4'h8;
      4'hC: subst = 4'h4;
      4'hD: subst = 4'h7;
      4'hE: subst = 4'h1;
      4'hF: subst = 4'h2;
      default: subst = 4'h0;
    endcase
  end

endmodule

// File: rtl/present_enc.sv
// Iterative PRESENT-80 encryption core, one round per clock, start/done handshake.
//
//   state   | meaning
//   IDLE    | waiting for start; ciphertext of last block held
//   RUN     | one round applied per cycle, ROUNDS cycles
//   DONE    | one-cycle done pulse, then back to IDLE
module present_enc
  import present_pkg::*;
#(
  parameter int ROUNDS = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] plaintext,
  input  logic [KEY_W-1:0]   key,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] ciphertext
);

  localparam logic [RC_W-1:0] LAST_ROUND = RC_W'(ROUNDS);

  logic [1:0]         fsm;
  logic [STATE_W-1:0] state;
  logic [KEY_W-1:0]   k;
  logic [RC_W-1:0]    round;

  logic [STATE_W-1:0] ark;
  logic [STATE_W-1:0] sub_out;
  logic [STATE_W-1:0] round_out;
  logic [KEY_W-1:0]   k_next;

  assign ark = state ^ k[KEY_W-1:KEY_W-STATE_W];

  for (genvar j = 0; j < STATE_W / 4; j++) begin : g_sbox
    sbox u_sbox (
      .nibble (ark[4*j +: 4]),
      .subst  (sub_out[4*j +: 4])
    );
  end

  assign round_out = player(sub_out);

  present_key_schedule u_key_schedule (
    .k      (k),
    .rc     (round),
    .k_next (k_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm   <= ST_IDLE;
      state <= '0;
      k     <= '0;
      round <= '0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (start) begin
            state <= plaintext;
            k     <= key;
            round <= RC_W'(1);
            fsm   <= ST_RUN;
          end
        end
        ST_RUN: begin
          state <= round_out;
          k     <= k_next;
          // Counter stops at the last round so it cannot wrap past 31.
          if (round == LAST_ROUND) begin
            fsm <= ST_DONE;
          end else begin
            round <= round + RC_W'(1);
          end
        end
        ST_DONE: fsm <= ST_IDLE;
        default: fsm <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (fsm == ST_RUN);
  assign done       = (fsm == ST_DONE);
  assign ciphertext = ark;

endmodule

// File: tb/tb_present_enc.sv
// Directed-vector bench for present_enc with a per-round reference model.
module tb_present_enc;
  import present_pkg::*;

  logic               clk;
  logic               rst;
  logic               start;
  logic [STATE_W-1:0] plaintext;
  logic [KEY_W-1:0]   key;
  logic               busy;
  logic               done;
  logic [STATE_W-1:0] ciphertext;

  int n_checks = 0;
  int n_fail   = 0;

  present_enc #(.ROUNDS(31)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .plaintext  (plaintext),
    .key        (key),
    .busy       (busy),
    .done       (done),
    .ciphertext (ciphertext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] sbox_ref(input logic [3:0] x);
    logic [63:0] t;
    t = S_TABLE;
    return t[4*x +: 4];
  endfunction

  function automatic logic [63:0] round_ref(input logic [63:0] s, input logic [79:0] kk);
    logic [63:0] a, b;
    a = s ^ kk[79:16];
    for (int j = 0; j < 16; j++) b[4*j +: 4] = sbox_ref(a[4*j +: 4]);
    return player(b);
  endfunction

  function automatic logic [79:0] ks_ref(input logic [79:0] kk, input logic [4:0] rc);
    logic [79:0] r;
    r = {kk[18:0], kk[79:19]};
    r[79:76] = sbox_ref(r[79:76]);
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

  // One encryption; glitch_at > 0 pulses start with other data during that RUN cycle.
  task automatic encrypt(input logic [63:0] pt, input logic [79:0] kin,
                         input logic [63:0] exp_ct, input int glitch_at);
    logic [63:0] ms;
    logic [79:0] mk;
    int busy_cnt;
    @(negedge clk);
    plaintext = pt;
    key       = kin;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ms = pt;
    mk = kin;
    busy_cnt = 0;
    check("load_state", {16'h0, dut.state}, {16'h0, ms});
    for (int r = 1; r <= 31; r++) begin
      if (busy) busy_cnt++;
      if (r == glitch_at) begin
        start     = 1'b1;
        plaintext = ~pt;
        key       = ~kin;
      end else begin
        start = 1'b0;
      end
      ms = round_ref(ms, mk);
      mk = ks_ref(mk, 5'(r));
      @(posedge clk); #1;
      check($sformatf("round_state_%0d", r), {16'h0, dut.state}, {16'h0, ms});
    end
    start = 1'b0;
    check("busy_cycles", 80'(busy_cnt), 80'd31);
    check("busy_low_at_done", 80'(busy), 80'd0);
    check("done_latency", 80'(done), 80'd1);
    check("ciphertext", {16'h0, ciphertext}, {16'h0, exp_ct});
    @(posedge clk); #1;
    check("done_one_cycle", 80'(done), 80'd0);
  endtask

  localparam logic [63:0] PT_ZERO = 64'h0;
  localparam logic [63:0] PT_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [79:0] K_ZERO  = 80'h0;
  localparam logic [79:0] K_ONES  = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

  initial begin
    int n_done, t1, t2;
    rst = 1'b1;
    start = 1'b0;
    plaintext = '0;
    key = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 80'(busy), 80'd0);
    check("reset_done", 80'(done), 80'd0);
    check("reset_ct", {16'h0, ciphertext}, 80'd0);
    @(negedge clk);
    rst = 1'b0;

    encrypt(PT_ZERO, K_ZERO, 64'h5579_C138_7B22_8445, 0);
    encrypt(PT_ZERO, K_ONES, 64'hE72C_46C0_F594_5049, 0);
    encrypt(PT_ONES, K_ZERO, 64'hA112_FFC7_2F68_417B, 0);
    encrypt(PT_ONES, K_ONES, 64'h3333_DCD3_2132_10D2, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_hold_ct", {16'h0, ciphertext}, {16'h0, 64'h3333_DCD3_2132_10D2});
    end

    // start during RUN must be ignored
    encrypt(PT_ZERO, K_ZERO, 64'h5579_C138_7B22_8445, 10);

    // reset in the middle of RUN aborts with no done pulse
    @(negedge clk);
    plaintext = PT_ONES;
    key = K_ONES;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
    end
    check("pre_abort_busy", 80'(busy), 80'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 80'(busy), 80'd0);
    check("abort_done", 80'(done), 80'd0);
    check("abort_ct", {16'h0, ciphertext}, 80'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("abort_no_done", 80'(n_done), 80'd0);
    encrypt(PT_ZERO, K_ZERO, 64'h5579_C138_7B22_8445, 0);

    // start held high: back-to-back blocks
    @(negedge clk);
    plaintext = PT_ZERO;
    key = K_ZERO;
    start = 1'b1;
    n_done = 0;
    t1 = 0;
    t2 = 0;
    for (int c = 1; c <= 100 && n_done < 2; c++) begin
      @(posedge clk); #1;
      if (done) begin
        if (n_done == 0) begin
          t1 = c;
          check("b2b_ct1", {16'h0, ciphertext}, {16'h0, 64'h5579_C138_7B22_8445});
          plaintext = PT_ZERO;
          key = K_ONES;
        end else begin
          t2 = c;
          check("b2b_ct2", {16'h0, ciphertext}, {16'h0, 64'hE72C_46C0_F594_5049});
        end
        n_done++;
      end
    end
    start = 1'b0;
    check("b2b_done_count", 80'(n_done), 80'd2);
    check("b2b_first_latency", 80'(t1), 80'd32);
    check("b2b_spacing", 80'(t2 - t1), 80'd33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
